bitrev_reorder: RTL and testbench

Ping-pong block reorder buffer: accepts a stream of samples in natural order and emits each complete block of BLOCK_SIZE samples in bit-reversed index order. It is the read-side counterpart of the delay line's bank-switching writer. It sits at the radix-2 FFT boundary, converting between natural and bit-reversed sample order, and flags the first sample of each output block for downstream symbol framing.

---
 rtl/bitrev_if.sv | 27 ++
 rtl/bitrev_reorder.sv | 122 ++++++++++++
 tb/tb_bitrev_reorder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitrev_if.sv
// Sample stream bundle for the bit-reversal reorder buffer.
// Master drives the natural-order samples; slave returns the reordered stream.
interface bitrev_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] in;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] out;
   logic                  out_valid;
   logic                  block_start;

   modport master (
      output in,
      output in_valid,
      input  out,
      input  out_valid,
      input  block_start
   );

   modport slave (
      input  in,
      input  in_valid,
      output out,
      output out_valid,
      output block_start
   );
endinterface

// File: rtl/bitrev_reorder.sv
// Ping-pong reorder buffer: fills one bank in natural order while the other bank
// is drained in bit-reversed index order, flagging index 0 of each output block.
module bitrev_reorder #(
   parameter int unsigned BLOCK_SIZE = 64,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic     clk,
   input  logic     reset,
   bitrev_if.slave  bus
);
   localparam int unsigned   LOG2 = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [LOG2-1:0] LAST_IDX = LOG2'(BLOCK_SIZE - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_READ = 1'b1;

   logic [DATA_WIDTH-1:0] mem_q [2*BLOCK_SIZE];

   logic [LOG2-1:0]       wr_cnt_q, wr_cnt_d;
   logic                  wr_bank_q, wr_bank_d;
   logic [LOG2-1:0]       rd_cnt_q, rd_cnt_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [0:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  out_valid_q, out_valid_d;
   logic                  block_start_q, block_start_d;

   logic                  wr_en_c;
   logic                  rd_start_c;

   function automatic logic [LOG2-1:0] bitrev(input logic [LOG2-1:0] x);
      logic [LOG2-1:0] r;
      r = '0;
      for (int i = 0; i < int'(LOG2); i++) begin
         r[i] = x[int'(LOG2) - 1 - i];
      end
      return r;
   endfunction

   // Write side: natural-order fill, bank hand-off on the last sample of a block.
   always_comb begin
      wr_en_c    = bus.in_valid;
      rd_start_c = wr_en_c && (wr_cnt_q == LAST_IDX);
      wr_cnt_d   = wr_cnt_q;
      wr_bank_d  = wr_bank_q;
      if (wr_en_c) begin
         wr_cnt_d = wr_cnt_q + LOG2'(1);
      end
      if (rd_start_c) begin
         wr_bank_d = ~wr_bank_q;
      end
   end

   // Sample storage is never cleared; a reset edge only suppresses the write.
   always_ff @(posedge clk) begin
      if (wr_en_c && !reset) begin
         mem_q[{wr_bank_q, wr_cnt_q}] <= bus.in;
      end
   end

   // Read FSM: a hand-off on the final read edge restarts immediately for gapless output.
   always_comb begin
      state_d       = state_q;
      rd_cnt_d      = rd_cnt_q;
      rd_bank_d     = rd_bank_q;
      out_d         = '0;
      out_valid_d   = 1'b0;
      block_start_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rd_start_c) begin
               state_d   = ST_READ;
               rd_cnt_d  = '0;
               rd_bank_d = wr_bank_q;
            end
         end
         ST_READ: begin
            out_d         = mem_q[{rd_bank_q, bitrev(rd_cnt_q)}];
            out_valid_d   = 1'b1;
            block_start_d = (rd_cnt_q == '0);
            rd_cnt_d      = rd_cnt_q + LOG2'(1);
            if (rd_cnt_q == LAST_IDX) begin
               if (rd_start_c) begin
                  rd_cnt_d  = '0;
                  rd_bank_d = wr_bank_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt_q      <= '0;
         wr_bank_q     <= 1'b0;
         rd_cnt_q      <= '0;
         rd_bank_q     <= 1'b0;
         state_q       <= ST_IDLE;
         out_q         <= '0;
         out_valid_q   <= 1'b0;
         block_start_q <= 1'b0;
      end else begin
         wr_cnt_q      <= wr_cnt_d;
         wr_bank_q     <= wr_bank_d;
         rd_cnt_q      <= rd_cnt_d;
         rd_bank_q     <= rd_bank_d;
         state_q       <= state_d;
         out_q         <= out_d;
         out_valid_q   <= out_valid_d;
         block_start_q <= block_start_d;
      end
   end

   assign bus.out         = out_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.block_start = block_start_q;
endmodule

// File: tb/tb_bitrev_reorder.sv
// Bench for bitrev_reorder: an 8-sample and a 64-sample instance checked every cycle
// against a block-level reorder model, plus literal sequences for the directed cases.
module tb_bitrev_reorder;
   localparam int unsigned DW   = 16;
   localparam int          MAXC = 4096;

   typedef int arr8_t [8];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [DW-1:0] in_v [2];
   logic          iv   [2];

   bitrev_if #(.DATA_WIDTH(DW)) bus8 ();
   bitrev_if #(.DATA_WIDTH(DW)) bus64 ();

   assign bus8.in        = in_v[0];
   assign bus8.in_valid  = iv[0];
   assign bus64.in       = in_v[1];
   assign bus64.in_valid = iv[1];

   bitrev_reorder #(.BLOCK_SIZE(8), .DATA_WIDTH(DW)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   bitrev_reorder #(.BLOCK_SIZE(64), .DATA_WIDTH(DW)) u_dut64 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus64)
   );

   logic [DW-1:0] o_d [2];
   logic          o_v [2];
   logic          o_b [2];
   always_comb begin
      o_d[0] = bus8.out;
      o_v[0] = bus8.out_valid;
      o_b[0] = bus8.block_start;
      o_d[1] = bus64.out;
      o_v[1] = bus64.out_valid;
      o_b[1] = bus64.block_start;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: partial block per instance and expected outputs indexed by edge number.
   int            fill [2];
   logic [DW-1:0] blk  [2][64];
   logic          ev   [2][MAXC];
   logic          eb   [2][MAXC];
   logic [DW-1:0] ed   [2][MAXC];

   function automatic int bsz(input int d);
      return (d == 0) ? 8 : 64;
   endfunction

   function automatic int lg(input int d);
      return (d == 0) ? 3 : 6;
   endfunction

   function automatic int rev(input int x, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) begin
         if (((x >> i) & 1) != 0) r = r | (1 << (bits - 1 - i));
      end
      return r;
   endfunction

   // Reorder model: a completed block at edge E yields element rev(k) at edge E+1+k.
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            fill[d] = 0;
            for (int c = cyc; c < cyc + 70 && c < MAXC; c++) begin
               ev[d][c] = 1'b0;
               eb[d][c] = 1'b0;
               ed[d][c] = '0;
            end
         end else if (iv[d]) begin
            blk[d][fill[d]] = in_v[d];
            fill[d] = fill[d] + 1;
            if (fill[d] == bsz(d)) begin
               for (int k = 0; k < bsz(d); k++) begin
                  if (cyc + 1 + k < MAXC) begin
                     ev[d][cyc+1+k] = 1'b1;
                     eb[d][cyc+1+k] = (k == 0);
                     ed[d][cyc+1+k] = blk[d][rev(k, lg(d))];
                  end
               end
               fill[d] = 0;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   initial forever begin
      @(negedge clk);
      if (cyc > 0 && cyc < MAXC) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_v[d] !== ev[d][cyc] || o_b[d] !== eb[d][cyc] || o_d[d] !== ed[d][cyc]) begin
               errors++;
               $display("FAIL model dut%0d edge %0d: got v=%0b bs=%0b out=%0d, want v=%0b bs=%0b out=%0d",
                        d, cyc, o_v[d], o_b[d], o_d[d], ev[d][cyc], eb[d][cyc], ed[d][cyc]);
            end
         end
      end
   end

   int cap0 [$];
   int cap1 [$];
   int first_out [2];
   int last_out  [2];
   int bs_cnt    [2];

   initial forever begin
      @(negedge clk);
      if (o_v[0] === 1'b1) begin
         if (cap0.size() == 0) first_out[0] = cyc;
         cap0.push_back(int'(o_d[0]));
         last_out[0] = cyc;
         if (o_b[0] === 1'b1) bs_cnt[0]++;
      end
      if (o_v[1] === 1'b1) begin
         if (cap1.size() == 0) first_out[1] = cyc;
         cap1.push_back(int'(o_d[1]));
         last_out[1] = cyc;
         if (o_b[1] === 1'b1) bs_cnt[1]++;
      end
   end

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic chk_seq8(input string nm, input int off, input arr8_t w);
      for (int i = 0; i < 8; i++) begin
         if (off + i < cap0.size()) chk($sformatf("%s[%0d]", nm, off + i), cap0[off+i], w[i]);
         else chk($sformatf("%s[%0d]_missing", nm, off + i), -1, w[i]);
      end
   endtask

   task automatic clr(input int d);
      if (d == 0) cap0.delete();
      else cap1.delete();
      first_out[d] = -1;
      last_out[d]  = -1;
      bs_cnt[d]    = 0;
   endtask

   task automatic drive(input int d, input int val, input logic v);
      @(negedge clk);
      in_v[d] = DW'(val);
      iv[d]   = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      arr8_t w;
      int    e;
      int    f;
      reset   = 1'b1;
      in_v[0] = '0;
      in_v[1] = '0;
      iv[0]   = 1'b0;
      iv[1]   = 1'b0;
      for (int d = 0; d < 2; d++) begin
         fill[d] = 0;
         for (int c = 0; c < MAXC; c++) begin
            ev[d][c] = 1'b0;
            eb[d][c] = 1'b0;
            ed[d][c] = '0;
         end
      end
      idle(3);
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_out%0d", d), int'(o_d[d]), 0);
         chk($sformatf("rst_valid%0d", d), int'(o_v[d]), 0);
         chk($sformatf("rst_bs%0d", d), int'(o_b[d]), 0);
      end

      // Single block.
      clr(0);
      for (int i = 0; i < 8; i++) drive(0, i, 1'b1);
      e = cyc + 1;
      drive(0, 0, 1'b0);
      idle(12);
      w = '{0, 4, 2, 6, 1, 5, 3, 7};
      chk("t1_len", cap0.size(), 8);
      chk_seq8("t1_seq", 0, w);
      chk("t1_latency", first_out[0] - e, 1);
      chk("t1_contig", last_out[0] - first_out[0], 7);
      chk("t1_bs_count", bs_cnt[0], 1);

      // Back-to-back blocks.
      clr(0);
      for (int i = 0; i < 32; i++) drive(0, i, 1'b1);
      drive(0, 0, 1'b0);
      idle(12);
      chk("t2_len", cap0.size(), 32);
      w = '{0, 4, 2, 6, 1, 5, 3, 7};
      chk_seq8("t2_seq", 0, w);
      w = '{8, 12, 10, 14, 9, 13, 11, 15};
      chk_seq8("t2_seq", 8, w);
      w = '{24, 28, 26, 30, 25, 29, 27, 31};
      chk_seq8("t2_seq", 24, w);
      chk("t2_contig", last_out[0] - first_out[0], 31);
      chk("t2_bs_count", bs_cnt[0], 4);

      // Input gaps.
      clr(0);
      for (int i = 0; i < 8; i++) begin
         drive(0, i, 1'b1);
         if (i != 7) drive(0, 0, 1'b0);
      end
      e = cyc + 1;
      drive(0, 0, 1'b0);
      idle(12);
      w = '{0, 4, 2, 6, 1, 5, 3, 7};
      chk("t3_len", cap0.size(), 8);
      chk_seq8("t3_seq", 0, w);
      chk("t3_latency", first_out[0] - e, 1);
      chk("t3_contig", last_out[0] - first_out[0], 7);

      // Reset mid-write.
      clr(0);
      for (int i = 0; i < 5; i++) drive(0, i, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      iv[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) drive(0, 100 + i, 1'b1);
      drive(0, 0, 1'b0);
      idle(12);
      w = '{100, 104, 102, 106, 101, 105, 103, 107};
      chk("t4_len", cap0.size(), 8);
      chk_seq8("t4_seq", 0, w);

      // Reset mid-read, asserted while the third output is visible.
      clr(0);
      for (int i = 0; i < 8; i++) drive(0, 40 + i, 1'b1);
      drive(0, 0, 1'b0);
      idle(3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_valid_after", int'(o_v[0]), 0);
      chk("t5_out_after", int'(o_d[0]), 0);
      idle(12);
      chk("t5_len", cap0.size(), 3);
      if (cap0.size() == 3) begin
         chk("t5_v0", cap0[0], 40);
         chk("t5_v1", cap0[1], 44);
         chk("t5_v2", cap0[2], 42);
      end

      // Default-size ramp.
      clr(1);
      drive(1, 0, 1'b1);
      f = cyc + 1;
      for (int i = 1; i < 1024; i++) drive(1, i, 1'b1);
      drive(1, 0, 1'b0);
      idle(70);
      chk("t6_len", cap1.size(), 1024);
      chk("t6_latency", first_out[1] - f, 64);
      chk("t6_contig", last_out[1] - first_out[1], 1023);
      chk("t6_bs_count", bs_cnt[1], 16);
      if (cap1.size() == 1024) begin
         chk("t6_k1", cap1[1], 32);
         chk("t6_b1k1", cap1[65], 96);
         chk("t6_b2k2", cap1[130], 144);
         chk("t6_last", cap1[1023], 1023);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
